// File: rtl/flash_access_arbiter_if.sv
// rtl/flash_access_arbiter_if.sv - client and flash-controller signal bundle for the flash access arbiter
interface flash_access_arbiter_if #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 8
);
   logic              c0_req;
   logic              c0_wr;
   logic [ADDR_W-1:0] c0_addr;
   logic [DATA_W-1:0] c0_wdata;
   logic [DATA_W-1:0] c0_rdata;
   logic              c0_ack;
   logic              c1_req;
   logic              c1_wr;
   logic [ADDR_W-1:0] c1_addr;
   logic [DATA_W-1:0] c1_wdata;
   logic [DATA_W-1:0] c1_rdata;
   logic              c1_ack;
   logic              f_we;
   logic              f_oe;
   logic [ADDR_W-1:0] f_address;
   logic [DATA_W-1:0] f_wdata;
   logic [DATA_W-1:0] f_rdata;
   logic              f_ready;
   logic              busy;
   logic              grant;
   logic              error;

   modport slave (
      input  c0_req, c0_wr, c0_addr, c0_wdata,
      input  c1_req, c1_wr, c1_addr, c1_wdata,
      input  f_rdata, f_ready,
      output c0_rdata, c0_ack, c1_rdata, c1_ack,
      output f_we, f_oe, f_address, f_wdata,
      output busy, grant, error
   );

   modport master (
      output c0_req, c0_wr, c0_addr, c0_wdata,
      output c1_req, c1_wr, c1_addr, c1_wdata,
      output f_rdata, f_ready,
      input  c0_rdata, c0_ack, c1_rdata, c1_ack,
      input  f_we, f_oe, f_address, f_wdata,
      input  busy, grant, error
   );
endinterface

// File: rtl/flash_access_arbiter.sv
// rtl/flash_access_arbiter.sv - round-robin arbiter sharing one byte-wide flash controller between two clients
module flash_access_arbiter #(
   parameter int ADDR_W  = 22,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   flash_access_arbiter_if.slave bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_ACK   = 3'd4;
   localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

   logic [2:0]        state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_q, last_d;
   logic              wr_q, wr_d;
   logic              error_q, error_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic [15:0]       wdog_q, wdog_d;
   logic              pick;
   logic              wdog_hit;

   assign pick     = (bus.c0_req && bus.c1_req) ? ~last_q : bus.c1_req;
   assign wdog_hit = (wdog_q == WDOG_LAST);

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      wr_d     = wr_q;
      error_d  = error_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         S_IDLE: begin
            if (bus.c0_req || bus.c1_req) begin
               grant_d = pick;
               wr_d    = pick ? bus.c1_wr    : bus.c0_wr;
               addr_d  = pick ? bus.c1_addr  : bus.c0_addr;
               wdata_d = pick ? bus.c1_wdata : bus.c0_wdata;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.f_ready) state_d = S_START;
         end
         S_START: begin
            if (!bus.f_ready) begin
               state_d = S_DONE;
            end else if (wdog_hit) begin
               error_d = 1'b1;
               state_d = S_ACK;
            end
         end
         S_DONE: begin
            if (bus.f_ready) begin
               if (!wr_q && !grant_q) rdata0_d = bus.f_rdata;
               if (!wr_q &&  grant_q) rdata1_d = bus.f_rdata;
               state_d = S_ACK;
            end else if (wdog_hit) begin
               error_d = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            last_d  = grant_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The watchdog only runs while waiting on the controller's ready edges after the strobe.
   always_comb begin
      wdog_d = wdog_q;
      if (state_d != state_q)
         wdog_d = '0;
      else if (state_q == S_START || state_q == S_DONE)
         wdog_d = wdog_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         grant_q  <= 1'b0;
         last_q   <= 1'b1;
         wr_q     <= 1'b0;
         error_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         wdog_q   <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         wr_q     <= wr_d;
         error_q  <= error_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         wdog_q   <= wdog_d;
      end
   end

   assign bus.f_we      = (state_q == S_ISSUE) && bus.f_ready &&  wr_q;
   assign bus.f_oe      = (state_q == S_ISSUE) && bus.f_ready && !wr_q;
   assign bus.f_address = addr_q;
   assign bus.f_wdata   = wdata_q;
   assign bus.c0_ack    = (state_q == S_ACK) && !grant_q;
   assign bus.c1_ack    = (state_q == S_ACK) &&  grant_q;
   assign bus.c0_rdata  = rdata0_q;
   assign bus.c1_rdata  = rdata1_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.grant     = grant_q;
   assign bus.error     = error_q;
endmodule

// File: tb/tb_flash_access_arbiter.sv
// tb/tb_flash_access_arbiter.sv - scoreboard bench for flash_access_arbiter with a flash controller model
module tb_flash_access_arbiter;
   localparam int AW = 22;
   localparam int DW = 8;
   localparam int TO = 16;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
   } txn_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   flash_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   flash_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_chk = 0;
   int n_pass = 0;

   txn_t exp0[$], exp1[$], drv0[$], drv1[$];
   int   ack_log[$];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   logic [DW-1:0] ref_rd [2];
   int   last_g;

   int   busy_fixed = 0;
   bit   stuck = 0;
   bit   force_low = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
   endtask

   task automatic fail_evt(input string name);
      n_chk++;
      $display("FAIL %s: event did not match the expected behaviour", name);
   endtask

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return a[7:0] ^ 8'h79;
   endfunction

   // Flash controller model: after a strobe it goes busy for a few cycles, then returns ready with data.
   logic [DW-1:0] fmem [logic [AW-1:0]];
   int            busy_left;
   bit            hung;
   logic [DW-1:0] pend;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_left   <= 0;
         hung        <= 1'b0;
         bus.f_ready <= 1'b1;
         bus.f_rdata <= '0;
      end else if (bus.f_we || bus.f_oe) begin
         if (bus.f_we) fmem[bus.f_address] = bus.f_wdata;
         pend        <= fmem.exists(bus.f_address) ? fmem[bus.f_address] : dflt(bus.f_address);
         busy_left   <= (busy_fixed > 0) ? busy_fixed : int'($urandom_range(1, 6));
         hung        <= stuck;
         bus.f_ready <= 1'b0;
      end else if (busy_left > 1) begin
         busy_left <= busy_left - 1;
      end else if (busy_left == 1) begin
         if (!hung) begin
            busy_left   <= 0;
            bus.f_ready <= !force_low;
            bus.f_rdata <= pend;
         end
      end else begin
         bus.f_ready <= !force_low;
      end
   end

   initial begin
      txn_t t;
      bus.c0_req = 1'b0; bus.c0_wr = 1'b0; bus.c0_addr = '0; bus.c0_wdata = '0;
      forever begin
         @(negedge clk);
         if (rst) bus.c0_req = 1'b0;
         else if (bus.c0_req) begin
            if (bus.c0_ack) bus.c0_req = 1'b0;
         end else if (drv0.size() > 0) begin
            t = drv0.pop_front();
            bus.c0_wr = t.wr; bus.c0_addr = t.addr; bus.c0_wdata = t.wdata; bus.c0_req = 1'b1;
         end
      end
   end

   initial begin
      txn_t t;
      bus.c1_req = 1'b0; bus.c1_wr = 1'b0; bus.c1_addr = '0; bus.c1_wdata = '0;
      forever begin
         @(negedge clk);
         if (rst) bus.c1_req = 1'b0;
         else if (bus.c1_req) begin
            if (bus.c1_ack) bus.c1_req = 1'b0;
         end else if (drv1.size() > 0) begin
            t = drv1.pop_front();
            bus.c1_wr = t.wr; bus.c1_addr = t.addr; bus.c1_wdata = t.wdata; bus.c1_req = 1'b1;
         end
      end
   end

   // Monitor: checks every strobe and every ack against the head of the granted client's queue.
   initial begin
      txn_t t;
      int   stb [2];
      int   c;
      stb = '{0, 0};
      forever begin
         @(negedge clk);
         if (rst) begin
            stb = '{0, 0};
         end else begin
            if (bus.f_we || bus.f_oe) begin
               c = int'(bus.grant);
               check("strobe_exclusive", 32'(bus.f_we & bus.f_oe), 0);
               check("strobe_ready", 32'(bus.f_ready), 1);
               if ((c == 0 && exp0.size() == 0) || (c == 1 && exp1.size() == 0)) begin
                  fail_evt("unexpected_strobe");
               end else begin
                  t = (c == 0) ? exp0[0] : exp1[0];
                  check("strobe_dir", 32'(bus.f_we), 32'(t.wr));
                  check("f_address", 32'(bus.f_address), 32'(t.addr));
                  if (t.wr) check("f_wdata", 32'(bus.f_wdata), 32'(t.wdata));
               end
               stb[c]++;
            end
            if (bus.c0_ack || bus.c1_ack) begin
               c = bus.c1_ack ? 1 : 0;
               check("ack_onehot", 32'(bus.c0_ack & bus.c1_ack), 0);
               check("ack_grant", 32'(bus.grant), 32'(c));
               if ((c == 0 && exp0.size() == 0) || (c == 1 && exp1.size() == 0)) begin
                  fail_evt("unexpected_ack");
               end else begin
                  t = (c == 0) ? exp0.pop_front() : exp1.pop_front();
                  if (c == 0) check("c0_rdata", 32'(bus.c0_rdata), 32'(t.rdata));
                  else        check("c1_rdata", 32'(bus.c1_rdata), 32'(t.rdata));
                  check("strobes_per_txn", 32'(stb[c]), 1);
               end
               stb[c] = 0;
               ack_log.push_back(c);
            end
         end
      end
   end

   task automatic issue(input int c, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input bit times_out);
      txn_t t;
      t.wr = wr; t.addr = a; t.wdata = wd;
      if (times_out) t.rdata = ref_rd[c];
      else if (wr) begin
         ref_mem[a] = wd;
         t.rdata = ref_rd[c];
      end else begin
         t.rdata = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
         ref_rd[c] = t.rdata;
      end
      if (c == 0) begin exp0.push_back(t); drv0.push_back(t); end
      else        begin exp1.push_back(t); drv1.push_back(t); end
   endtask

   task automatic wait_idle(input int budget);
      int  k;
      bit  done;
      k = 0; done = 0;
      while (!done && k < budget) begin
         @(negedge clk);
         k++;
         done = exp0.size() == 0 && exp1.size() == 0 && drv0.size() == 0 && drv1.size() == 0
                && !bus.busy && !bus.c0_req && !bus.c1_req;
      end
      if (!done) fail_evt("wait_idle_timeout");
   endtask

   task automatic wait_strobe();
      bit seen;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = bus.f_we || bus.f_oe;
      end
      if (!seen) fail_evt("wait_strobe_timeout");
   endtask

   task automatic chk_order(input int n, input int first);
      for (int i = 0; i < n; i++) begin
         if (ack_log.size() > i) check($sformatf("grant_order_%0d", i), 32'(ack_log[i]), 32'((first + i) % 2));
         else fail_evt($sformatf("grant_order_%0d_missing", i));
      end
      last_g = (first + n - 1) % 2;
   endtask

   task automatic chk_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 0);
      check({tag, "_grant"}, 32'(bus.grant), 0);
      check({tag, "_error"}, 32'(bus.error), 0);
      check({tag, "_acks"}, 32'({bus.c0_ack, bus.c1_ack}), 0);
      check({tag, "_strobes"}, 32'({bus.f_we, bus.f_oe}), 0);
      check({tag, "_f_address"}, 32'(bus.f_address), 0);
      check({tag, "_f_wdata"}, 32'(bus.f_wdata), 0);
      check({tag, "_rdata"}, 32'({bus.c0_rdata, bus.c1_rdata}), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      exp0.delete(); exp1.delete(); drv0.delete(); drv1.delete(); ack_log.delete();
      ref_rd = '{8'h00, 8'h00};
      last_g = 1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int first;
      int sel;
      int k;
      logic [AW-1:0] a;
      rst = 1'b1;
      last_g = 1;
      ref_rd = '{8'h00, 8'h00};
      #1;
      chk_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      busy_fixed = 6;
      issue(0, 1'b0, 22'h000123, 8'h00, 0);
      wait_idle(100);
      check("t1_c0_rdata", 32'(bus.c0_rdata), 32'h5A);
      check("t1_grant", 32'(bus.grant), 0);
      check("t1_busy", 32'(bus.busy), 0);
      last_g = 0;

      do_reset();
      busy_fixed = 0;
      ack_log.delete();
      issue(0, 1'b1, 22'h000010, 8'h3C, 0);
      issue(1, 1'b0, 22'h000020, 8'h00, 0);
      first = 1 - last_g;
      wait_idle(200);
      chk_order(2, first);

      @(negedge clk);
      force_low = 1;
      @(negedge clk);
      issue(1, 1'b1, 22'h200040, 8'h3C, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t3_no_we_while_busy", 32'(bus.f_we), 0);
      end
      force_low = 0;
      wait_idle(100);
      check("t3_c1_rdata_kept", 32'(bus.c1_rdata), 32'(ref_rd[1]));
      last_g = 1;

      for (int r = 0; r < 16; r++) begin
         sel = int'($urandom_range(1, 3));
         ack_log.delete();
         for (int c = 0; c < 2; c++) begin
            if (sel[c]) begin
               a = {1'(c), 17'd0, 4'($urandom)};
               issue(c, 1'($urandom), a, 8'($urandom), 0);
            end
         end
         first = (sel == 3) ? 1 - last_g : ((sel == 1) ? 0 : 1);
         wait_idle(200);
         chk_order((sel == 3) ? 2 : 1, first);
      end

      ack_log.delete();
      for (int i = 0; i < 4; i++) begin
         issue(0, 1'($urandom), {1'b0, 17'd0, 4'($urandom)}, 8'($urandom), 0);
         issue(1, 1'($urandom), {1'b1, 17'd0, 4'($urandom)}, 8'($urandom), 0);
      end
      first = 1 - last_g;
      wait_idle(400);
      chk_order(8, first);

      // Hung controller: one START cycle, then TIMEOUT cycles in DONE before error and ack.
      stuck = 1;
      issue(0, 1'b0, 22'h000055, 8'h00, 1);
      wait_strobe();
      k = 0;
      while (!bus.error && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("t5_error_delay", 32'(k), 32'(TO + 2));
      repeat (5) @(negedge clk);
      check("t5_error_sticky", 32'(bus.error), 1);
      check("t5_idle_after_timeout", 32'(bus.busy), 0);
      check("t5_acked", 32'(exp0.size()), 0);
      stuck = 0;

      do_reset();
      check("t6_error_cleared", 32'(bus.error), 0);
      busy_fixed = 6;
      issue(1, 1'b0, 22'h200077, 8'h00, 0);
      wait_strobe();
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk_reset_outputs("t6_midreset");
      exp1.delete();
      ref_rd = '{8'h00, 8'h00};
      last_g = 1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      busy_fixed = 0;
      ack_log.delete();
      issue(1, 1'b0, 22'h200033, 8'h00, 0);
      wait_idle(100);
      chk_order(1, 1);
      check("t6_c1_rdata", 32'(bus.c1_rdata), 32'(dflt(22'h200033)));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
